// File: rtl/fontload_ctrl.sv
// Font loader: copies COUNT staged words from the staging buffer into one SPRAM page under the
// character generator's grant. Optional readback verification is enabled with FONTLOAD_VERIFY_EN.
module fontload_ctrl #(
  parameter int COUNT    = 256,
  parameter int SPRAM_AW = 14
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [SPRAM_AW-9:0]   page,
  output logic                  busy,
  output logic                  done,
  input  logic                  host_wr,
  input  logic [7:0]            host_addr,
  input  logic [15:0]           host_data,
  output logic                  host_drop,
  output logic                  buf_rd,
  output logic [7:0]            buf_rd_addr,
  input  logic [15:0]           buf_rd_data,
  output logic                  buf_wr,
  output logic [7:0]            buf_wr_addr,
  output logic [15:0]           buf_wr_data,
  output logic                  spram_req,
  input  logic                  spram_gnt,
  output logic                  spram_we,
  output logic [SPRAM_AW-1:0]   spram_addr,
  output logic [15:0]           spram_wdata,
  input  logic [15:0]           spram_rdata,
  output logic                  verify_err
);

  // state    | meaning
  // S_IDLE   | host owns the staging buffer, waiting for start
  // S_COPY   | reading buffer words and writing them to SPRAM while granted
  // S_DRAIN  | all words read, waiting for the last pending write
  // S_VERIFY | (FONTLOAD_VERIFY_EN) re-reading buffer and SPRAM, comparing
  // S_DONE   | one-cycle completion, done pulse
`ifdef FONTLOAD_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_COPY, S_DRAIN, S_VERIFY, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COPY, S_DRAIN, S_DONE} state_t;
`endif

  localparam logic [8:0] CNT = 9'(COUNT);

  state_t                state;
  logic [8:0]            index;
  logic [7:0]            wr_idx;
  logic                  pending;
  logic [SPRAM_AW-9:0]   page_q;
  logic                  rd_copy;
  logic                  wr_fire;
  logic                  rd_verify;

  assign rd_copy   = (state == S_COPY) && spram_gnt && (index < CNT);
  assign wr_fire   = pending && spram_gnt && ((state == S_COPY) || (state == S_DRAIN));
`ifdef FONTLOAD_VERIFY_EN
  assign rd_verify = (state == S_VERIFY) && spram_gnt && (index < CNT);
`else
  assign rd_verify = 1'b0;
`endif

  assign buf_rd      = rd_copy | rd_verify;
  assign buf_rd_addr = index[7:0];
  assign spram_we    = wr_fire;
  assign spram_wdata = buf_rd_data;
  // Verification reads address SPRAM with the live index; copy writes use the captured one.
  assign spram_addr  = rd_verify ? {page_q, index[7:0]} : {page_q, wr_idx};

  // Host writes pass straight through only while the loader is idle and out of reset.
  assign buf_wr      = nrst & ~busy & host_wr;
  assign buf_wr_addr = host_addr;
  assign buf_wr_data = host_data;

`ifdef FONTLOAD_VERIFY_EN
  logic cmp_pend;
`else
  logic unused_rdata;
  assign unused_rdata = ^spram_rdata;
  assign verify_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      index     <= '0;
      wr_idx    <= '0;
      pending   <= 1'b0;
      page_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spram_req <= 1'b0;
      host_drop <= 1'b0;
`ifdef FONTLOAD_VERIFY_EN
      cmp_pend   <= 1'b0;
      verify_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (busy && host_wr) host_drop <= 1'b1;
      if (buf_rd) index <= index + 9'd1;
      if (rd_copy) begin
        wr_idx  <= index[7:0];
        pending <= 1'b1;
      end else if (wr_fire) begin
        pending <= 1'b0;
      end
`ifdef FONTLOAD_VERIFY_EN
      cmp_pend <= rd_verify;
      if (cmp_pend && (buf_rd_data != spram_rdata)) verify_err <= 1'b1;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            page_q    <= page;
            index     <= '0;
            host_drop <= 1'b0;
`ifdef FONTLOAD_VERIFY_EN
            verify_err <= 1'b0;
`endif
            busy      <= 1'b1;
            spram_req <= 1'b1;
            state     <= S_COPY;
          end
        end
        S_COPY: begin
          if (index == CNT) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!pending || wr_fire) begin
`ifdef FONTLOAD_VERIFY_EN
            index <= '0;
            state <= S_VERIFY;
`else
            done      <= 1'b1;
            spram_req <= 1'b0;
            state     <= S_DONE;
`endif
          end
        end
`ifdef FONTLOAD_VERIFY_EN
        S_VERIFY: begin
          // Leave only after the last readback has been compared.
          if ((index == CNT) && !cmp_pend) begin
            done      <= 1'b1;
            spram_req <= 1'b0;
            state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fontload_ctrl.sv
// Scoreboard bench for fontload_ctrl: expected SPRAM writes and done cycles are queued at
// stimulus time and popped by negedge monitors; a COUNT=1 instance covers the single-word case.
module tb_fontload_ctrl;
  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [5:0]  page;
  logic        busy, done, host_wr, host_drop;
  logic [7:0]  host_addr;
  logic [15:0] host_data;
  logic        buf_rd, buf_wr;
  logic [7:0]  buf_rd_addr, buf_wr_addr;
  logic [15:0] buf_rd_data, buf_wr_data;
  logic        spram_req, spram_gnt, spram_we, verify_err;
  logic [13:0] spram_addr;
  logic [15:0] spram_wdata, spram_rdata;

  logic        start1, busy1, done1, host_wr1, host_drop1;
  logic [7:0]  host_addr1;
  logic [15:0] host_data1;
  logic        buf_rd1, buf_wr1;
  logic [7:0]  buf_rd_addr1, buf_wr_addr1;
  logic [15:0] buf_rd_data1, buf_wr_data1;
  logic        spram_req1, spram_we1, verify_err1;
  logic [13:0] spram_addr1;
  logic [15:0] spram_wdata1, spram_rdata1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0, done_cnt = 0, wr1_cnt = 0, done1_cnt = 0;
  logic [29:0] exp_q[$];
  int          done_q[$];
  logic [29:0] exp1_q[$];
  int          done1_q[$];
  logic        gnt_toggle = 1'b0;
  logic        corrupt = 1'b0;

  logic [15:0] buf_mem [0:255];
  logic [15:0] sp_mem  [0:16383];
  logic [15:0] buf1_mem [0:255];
  logic [15:0] sp1_mem  [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fontload_ctrl #(.COUNT(256), .SPRAM_AW(14)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .page(page), .busy(busy), .done(done),
    .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data), .host_drop(host_drop),
    .buf_rd(buf_rd), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .buf_wr(buf_wr), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .spram_req(spram_req), .spram_gnt(spram_gnt), .spram_we(spram_we), .spram_addr(spram_addr),
    .spram_wdata(spram_wdata), .spram_rdata(spram_rdata), .verify_err(verify_err));

  fontload_ctrl #(.COUNT(1), .SPRAM_AW(14)) u_dut1 (
    .clk(clk), .nrst(nrst), .start(start1), .page(page), .busy(busy1), .done(done1),
    .host_wr(host_wr1), .host_addr(host_addr1), .host_data(host_data1), .host_drop(host_drop1),
    .buf_rd(buf_rd1), .buf_rd_addr(buf_rd_addr1), .buf_rd_data(buf_rd_data1),
    .buf_wr(buf_wr1), .buf_wr_addr(buf_wr_addr1), .buf_wr_data(buf_wr_data1),
    .spram_req(spram_req1), .spram_gnt(1'b1), .spram_we(spram_we1), .spram_addr(spram_addr1),
    .spram_wdata(spram_wdata1), .spram_rdata(spram_rdata1), .verify_err(verify_err1));

  // Staging buffer and SPRAM models: registered reads, buffer data held while buf_rd is low.
  always @(posedge clk) begin
    if (buf_wr) buf_mem[buf_wr_addr] <= buf_wr_data;
    if (buf_rd) buf_rd_data <= buf_mem[buf_rd_addr];
    if (spram_we) sp_mem[spram_addr] <= spram_wdata;
    else spram_rdata <= (corrupt && spram_addr == 14'h0342) ? (sp_mem[spram_addr] ^ 16'h0001)
                                                           : sp_mem[spram_addr];
    if (buf_wr1) buf1_mem[buf_wr_addr1] <= buf_wr_data1;
    if (buf_rd1) buf_rd_data1 <= buf1_mem[buf_rd_addr1];
    if (spram_we1) sp1_mem[spram_addr1[7:0]] <= spram_wdata1;
    else spram_rdata1 <= sp1_mem[spram_addr1[7:0]];
  end

  initial begin : gnt_drv
    int ph = 0;
    spram_gnt = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (gnt_toggle) begin
        spram_gnt = (ph < 3);
        ph = (ph + 1) % 6;
      end else begin
        spram_gnt = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    logic [29:0] e;
    int dc;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (spram_we) begin
          wr_cnt++;
          chk("we_with_gnt", {31'd0, spram_gnt}, 32'd1);
          if (exp_q.size() == 0) chk("unexpected_write", {18'd0, spram_addr}, 32'hFFFFFFFF);
          else begin
            e = exp_q.pop_front();
            chk("spram_write", {2'd0, spram_addr, spram_wdata}, {2'd0, e});
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_at_done", {31'd0, busy}, 32'd1);
          if (done_q.size() == 0) chk("unexpected_done", cyc, 32'hFFFFFFFF);
          else begin
            dc = done_q.pop_front();
            if (dc != 0) chk("done_cycle", cyc, dc);
          end
        end
        if (spram_we1) begin
          wr1_cnt++;
          if (exp1_q.size() == 0) chk("unexpected_write1", {18'd0, spram_addr1}, 32'hFFFFFFFF);
          else begin
            e = exp1_q.pop_front();
            chk("spram_write1", {2'd0, spram_addr1, spram_wdata1}, {2'd0, e});
          end
        end
        if (done1) begin
          done1_cnt++;
          if (done1_q.size() == 0) chk("unexpected_done1", cyc, 32'hFFFFFFFF);
          else begin
            dc = done1_q.pop_front();
            if (dc != 0) chk("done1_cycle", cyc, dc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_load(input logic [5:0] p);
    for (int i = 0; i < 256; i++)
      exp_q.push_back({p, 8'(i), 16'(i) ^ 16'hA5A5});
  endtask

  // Start pulse; done is expected 259 cycles after the drive point when no verify pass runs.
  task automatic do_start(input logic [5:0] p, input bit timed);
    step();
    start = 1'b1;
    page  = p;
`ifdef FONTLOAD_VERIFY_EN
    done_q.push_back(0);
`else
    done_q.push_back(timed ? cyc + 259 : 0);
`endif
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s: no done after %0d cycles, expected a done pulse", nm, n);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_buf_rd"}, {31'd0, buf_rd}, 32'd0);
    chk({nm, "_buf_wr"}, {31'd0, buf_wr}, 32'd0);
    chk({nm, "_req"}, {31'd0, spram_req}, 32'd0);
    chk({nm, "_we"}, {31'd0, spram_we}, 32'd0);
    chk({nm, "_drop"}, {31'd0, host_drop}, 32'd0);
    chk({nm, "_verr"}, {31'd0, verify_err}, 32'd0);
    chk({nm, "_addr"}, {18'd0, spram_addr}, 32'd0);
    chk({nm, "_rdaddr"}, {24'd0, buf_rd_addr}, 32'd0);
  endtask

  initial begin : stim
    int w0, d0;
    nrst = 1'b0; start = 1'b0; page = '0;
    host_wr = 1'b1; host_addr = 8'h12; host_data = 16'h3456;
    start1 = 1'b0; host_wr1 = 1'b0; host_addr1 = '0; host_data1 = '0;
    repeat (3) step();
    chk_reset_outputs("rst0");
    host_wr = 1'b0;
    step();
    nrst = 1'b1;
    step();

    // Load the staging buffer with addr ^ A5A5 through the idle passthrough.
    for (int i = 0; i < 256; i++) begin
      step();
      host_wr = 1'b1; host_addr = 8'(i); host_data = 16'(i) ^ 16'hA5A5;
    end
    step();
    host_wr = 1'b0;

    // Full copy with grant held: page 3, fixed completion latency.
    w0 = wr_cnt;
    push_load(6'd3);
    do_start(6'd3, 1'b1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("req_after_start", {31'd0, spram_req}, 32'd1);
    wait_done("t1_done");
    chk("t1_writes", wr_cnt - w0, 32'd256);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    chk("t1_req_idle", {31'd0, spram_req}, 32'd0);
    chk("t1_mem_0300", {16'd0, sp_mem[14'h0300]}, 32'hA5A5);
    chk("t1_mem_0342", {16'd0, sp_mem[14'h0342]}, 32'hA5E7);
    chk("t1_mem_03FF", {16'd0, sp_mem[14'h03FF]}, 32'hA55A);
    chk("t1_verr", {31'd0, verify_err}, 32'd0);

    // Grant toggling 3 on / 3 off during the copy to page 5.
    w0 = wr_cnt;
    gnt_toggle = 1'b1;
    push_load(6'd5);
    do_start(6'd5, 1'b0);
    wait_done("t2_done");
    gnt_toggle = 1'b0;
    chk("t2_writes", wr_cnt - w0, 32'd256);
    chk("t2_mem_05FF", {16'd0, sp_mem[14'h05FF]}, 32'hA55A);

    // Host writes while busy are dropped and flagged.
    w0 = wr_cnt;
    push_load(6'd6);
    do_start(6'd6, 1'b1);
    repeat (4) step();
    host_wr = 1'b1; host_addr = 8'h10; host_data = 16'hFFFF;
    #1 chk("t3_buf_wr_gated", {31'd0, buf_wr}, 32'd0);
    repeat (3) step();
    host_wr = 1'b0;
    chk("t3_drop_set", {31'd0, host_drop}, 32'd1);
    wait_done("t3_done");
    chk("t3_writes", wr_cnt - w0, 32'd256);
    chk("t3_buf_unchanged", {16'd0, buf_mem[8'h10]}, 32'hA5B5);
    chk("t3_drop_sticky", {31'd0, host_drop}, 32'd1);

    // Next start clears the drop flag; reset after 100 writes abandons the load.
    push_load(6'd7);
    do_start(6'd7, 1'b1);
    chk("t4_drop_cleared", {31'd0, host_drop}, 32'd0);
    w0 = wr_cnt;
    for (int n = 0; n < 400 && (wr_cnt - w0) < 100; n++) step();
    chk("t4_reached_100", {31'd0, (wr_cnt - w0) >= 100}, 32'd1);
    nrst = 1'b0;
    exp_q.delete();
    done_q.delete();
    d0 = done_cnt;
    #1 chk_reset_outputs("rst_mid");
    repeat (2) step();
    nrst = 1'b1;
    repeat (3) step();
    chk("t4_no_done", done_cnt, d0);
    w0 = wr_cnt;
    push_load(6'd7);
    do_start(6'd7, 1'b1);
    wait_done("t4_done");
    chk("t4_writes", wr_cnt - w0, 32'd256);
    chk("t4_mem_0780", {16'd0, sp_mem[14'h0780]}, 32'hA525);

    // COUNT=1 instance: one write, repeated starts while busy ignored.
    step();
    host_wr1 = 1'b1; host_addr1 = 8'h00; host_data1 = 16'h1234;
    step();
    host_wr1 = 1'b0;
    exp1_q.push_back({6'd2, 8'h00, 16'h1234});
    start1 = 1'b1; page = 6'd2;
`ifdef FONTLOAD_VERIFY_EN
    done1_q.push_back(0);
`else
    done1_q.push_back(cyc + 4);
`endif
    step(); start1 = 1'b0;
    step(); start1 = 1'b1;
    step();
    step(); start1 = 1'b0;
    repeat (12) step();
    chk("t5_writes", wr1_cnt, 32'd1);
    chk("t5_done_count", done1_cnt, 32'd1);
    chk("t5_mem_0200", {16'd0, sp1_mem[8'h00]}, 32'h1234);

`ifdef FONTLOAD_VERIFY_EN
    push_load(6'd3);
    do_start(6'd3, 1'b0);
    wait_done("t6_done");
    chk("t6_verr_clean", {31'd0, verify_err}, 32'd0);
    corrupt = 1'b1;
    push_load(6'd3);
    do_start(6'd3, 1'b0);
    wait_done("t7_done");
    chk("t7_verr_corrupt", {31'd0, verify_err}, 32'd1);
    corrupt = 1'b0;
`endif

    repeat (5) step();
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fontload_ctrl.md
FONTLOAD_CTRL -- requirements
Module: fontload_ctrl

Interface
REQ-001 Parameter: COUNT, 256, number of staged words copied per load (legal 1..256).
REQ-002 Parameter: SPRAM_AW, 14, SPRAM word-address width.
REQ-003 Port: clk  in  1  sole clock, all state on rising edge.
REQ-004 Port: nrst  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  pulse, begin a load.
REQ-006 Port: page  in  SPRAM_AW-8  destination page; SPRAM address = {page, word index}.
REQ-007 Port: busy  out  1  high from load accept until return to IDLE.
REQ-008 Port: done  out  1  one-cycle pulse at load completion.
REQ-009 Port: host_wr / host_addr / host_data  in  1 / 8 / 16  host staging write.
REQ-010 Port: host_drop  out  1  sticky flag, host write discarded while busy.
REQ-011 Port: buf_rd / buf_rd_addr / buf_rd_data  out 1 / out 8 / in 16  staging-buffer read port; data one cycle after buf_rd, held while buf_rd low.
REQ-012 Port: buf_wr / buf_wr_addr / buf_wr_data  out  1 / 8 / 16  staging-buffer write port.
REQ-013 Port: spram_req / spram_gnt  out 1 / in 1  SPRAM ownership handshake with character generator.
REQ-014 Port: spram_we / spram_addr / spram_wdata / spram_rdata  out 1 / out SPRAM_AW / out 16 / in 16  SPRAM port; rdata one cycle after address with we low.
REQ-015 Port: verify_err  out  1  sticky readback mismatch flag.

Function
REQ-016 States: IDLE, COPY, DRAIN, VERIFY (macro only), DONE.
REQ-017 IDLE: buf_wr=host_wr, buf_wr_addr=host_addr, buf_wr_data=host_data, combinational passthrough.
REQ-018 busy=1: buf_wr=0; any host_wr sets host_drop; host_drop cleared only by start accepted in IDLE or reset.
REQ-019 start in IDLE: latch page, index=0, clear host_drop and verify_err, go COPY next cycle; start outside IDLE ignored.
REQ-020 spram_req=1 in COPY, DRAIN, VERIFY; 0 in IDLE and DONE.
REQ-021 COPY: buf_rd=spram_gnt AND index<COUNT; buf_rd_addr=index[7:0]; index increments on each buf_rd; index 9 bits, no wrap at 256.
REQ-022 Pending flag set by buf_rd, cleared by a write cycle without new buf_rd; write address register captures index at read.
REQ-023 spram_we=pending AND spram_gnt; spram_addr={page, captured index}; spram_wdata=buf_rd_data.
REQ-024 gnt low mid-copy: no reads, no writes, pending word retained (buffer holds rd_data); resume exactly where stopped on gnt return, no word lost or duplicated.
REQ-025 Sustained gnt: one word per cycle; first spram_we one cycle after first buf_rd; COUNT writes total.
REQ-026 index==COUNT: go DRAIN; DRAIN exits when pending clear and last write done.
REQ-027 DONE: done=1 one cycle, busy still 1 that cycle; next state IDLE.
REQ-028 spram_we never asserted outside COPY/DRAIN, never with spram_gnt=0.

Reset
REQ-029 nrst low, any state: IDLE, index=0, pending=0; busy, done, buf_rd, buf_wr, spram_req, spram_we, host_drop, verify_err all 0; spram_addr and buf_rd_addr 0.
REQ-030 Reset mid-load abandons the load; partially written SPRAM contents left as-is; no done pulse.

Configuration
REQ-031 Macro FONTLOAD_VERIFY_EN defined: DRAIN goes VERIFY; index re-run 0..COUNT-1, reading buffer and SPRAM (we=0) together under gnt, same stall rules; one-cycle-later compare; any mismatch sets verify_err; then DONE.
REQ-032 Macro undefined: no VERIFY state, DRAIN goes DONE, verify_err tied 0.

Verification
REQ-033 Host writes 256 words data=addr^16'hA5A5 in IDLE, start page=3, gnt held 1 -> SPRAM 0x0300..0x03FF hold the pattern, done exactly 258 cycles after start (no verify).
REQ-034 gnt toggled 1/0 every 3 cycles during copy -> identical SPRAM contents, no we while gnt=0, COUNT writes total.
REQ-035 host_wr during busy -> host_drop=1, buffer unchanged, copied data unaffected; next start clears host_drop.
REQ-036 nrst pulsed after 100 writes -> outputs per REQ-029 immediately, no done; fresh start completes full load.
REQ-037 COUNT=1, start repeated while busy -> one write at {page,0}, second start ignored, one done pulse.
REQ-038 FONTLOAD_VERIFY_EN, SPRAM model corrupts word 0x0342 -> verify_err=1 at done; clean run -> verify_err=0.
